// File: rtl/gpio_port.sv
// Register-mapped bidirectional GPIO port for one group of pads: direction/output control,
// synchronised input sampling, per-bit edge detection and a level interrupt.
module gpio_port #(
    parameter int unsigned ID    = 0,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       adr,
    input  logic             we,
    input  logic             re,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    input  logic [WIDTH-1:0] pad_in,
    output logic             irq
);

    localparam logic [2:0] AdrDir   = 3'd0;
    localparam logic [2:0] AdrOut   = 3'd1;
    localparam logic [2:0] AdrIn    = 3'd2;
    localparam logic [2:0] AdrIflg  = 3'd3;
    localparam logic [2:0] AdrIen   = 3'd4;
    localparam logic [2:0] AdrIedge = 3'd5;
    localparam logic [2:0] AdrOtgl  = 3'd6;
    localparam logic [2:0] AdrId    = 3'd7;

    localparam logic [7:0] IdVal = 8'(ID);

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] iflg_q, iflg_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] iedge_q, iedge_d;
    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [7:0]       rdata_q, rdata_d;

    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] flg_clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [7:0]       rd_val;

    function automatic logic [7:0] zext(input logic [WIDTH-1:0] v);
        logic [7:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign wdata_w = wdata[WIDTH-1:0];

    // Register write decode
    always_comb begin
        dir_d   = dir_q;
        out_d   = out_q;
        ien_d   = ien_q;
        iedge_d = iedge_q;
        flg_clr = '0;
        if (we) begin
            case (adr)
                AdrDir:   dir_d   = wdata_w;
                AdrOut:   out_d   = wdata_w;
                AdrIflg:  flg_clr = wdata_w;
                AdrIen:   ien_d   = wdata_w;
                AdrIedge: iedge_d = wdata_w;
                AdrOtgl:  out_d   = out_q ^ wdata_w;
                default:  ;
            endcase
        end
    end

    // Edge events come only from s2/s3, so reprogramming IEDGE cannot fake an edge.
    always_comb begin
        rise   = s2_q & ~s3_q;
        fall   = ~s2_q & s3_q;
        ev     = (iedge_q & rise) | (~iedge_q & fall);
        iflg_d = (iflg_q & ~flg_clr) | ev;
    end

    // Read mux sees pre-write values, so a simultaneous we/re returns the old contents.
    always_comb begin
        rd_val = '0;
        case (adr)
            AdrDir:   rd_val = zext(dir_q);
            AdrOut:   rd_val = zext(out_q);
            AdrIn:    rd_val = zext(s2_q);
            AdrIflg:  rd_val = zext(iflg_q);
            AdrIen:   rd_val = zext(ien_q);
            AdrIedge: rd_val = zext(iedge_q);
            AdrOtgl:  rd_val = '0;
            AdrId:    rd_val = IdVal;
            default:  rd_val = '0;
        endcase
        rdata_d = re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q   <= '0;
            out_q   <= '0;
            iflg_q  <= '0;
            ien_q   <= '0;
            iedge_q <= '1;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            rdata_q <= '0;
        end else begin
            dir_q   <= dir_d;
            out_q   <= out_d;
            iflg_q  <= iflg_d;
            ien_q   <= ien_d;
            iedge_q <= iedge_d;
            s1_q    <= pad_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            rdata_q <= rdata_d;
        end
    end

    assign pad_oe  = dir_q;
    assign pad_out = out_q;
    assign irq     = |(iflg_q & ien_q);
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: table-driven register accesses plus hand-timed
// sequences for edge detection, flag collision and mid-operation reset.
module tb_gpio_port;

    localparam logic [7:0] TbId  = 8'h5A;
    localparam logic [7:0] TbId4 = 8'h03;

    logic       clk;
    logic       rst_n;
    logic [2:0] adr;
    logic       we;
    logic       re;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] pad_out;
    logic [7:0] pad_oe;
    logic [7:0] pad_in;
    logic       irq;

    logic [7:0] rdata4;
    logic [3:0] pad_out4;
    logic [3:0] pad_oe4;
    logic       irq4;

    int checks;
    int failures;

    gpio_port #(.ID(32'h5A), .WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .adr     (adr),
        .we      (we),
        .re      (re),
        .wdata   (wdata),
        .rdata   (rdata),
        .pad_out (pad_out),
        .pad_oe  (pad_oe),
        .pad_in  (pad_in),
        .irq     (irq)
    );

    gpio_port #(.ID(32'h03), .WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .adr     (adr),
        .we      (we),
        .re      (re),
        .wdata   (wdata),
        .rdata   (rdata4),
        .pad_out (pad_out4),
        .pad_oe  (pad_oe4),
        .pad_in  (pad_in[3:0]),
        .irq     (irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_wr;
        logic [2:0] adr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic [7:0] exp_oe;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        adr   = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        adr = a;
        re  = 1'b1;
        tick();
        re  = 1'b0;
        d   = rdata;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    logic [7:0] rd;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        adr      = '0;
        we       = 1'b0;
        re       = 1'b0;
        wdata    = '0;
        pad_in   = '0;

        // {is_wr, adr, data, exp_rdata, exp_oe, exp_out}
        vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 3'd5, 8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 3'd6, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 3'd7, 8'h00, TbId,  8'h00, 8'h00};
        vecs[8]  = '{1'b1, 3'd0, 8'hF0, 8'h00, 8'hF0, 8'h00};
        vecs[9]  = '{1'b1, 3'd1, 8'hA5, 8'h00, 8'hF0, 8'hA5};
        vecs[10] = '{1'b1, 3'd6, 8'h0F, 8'h00, 8'hF0, 8'hAA};
        vecs[11] = '{1'b0, 3'd1, 8'h00, 8'hAA, 8'hF0, 8'hAA};
        vecs[12] = '{1'b0, 3'd6, 8'h00, 8'h00, 8'hF0, 8'hAA};
        vecs[13] = '{1'b0, 3'd0, 8'h00, 8'hF0, 8'hF0, 8'hAA};

        tick_n(2);
        rst_n = 1'b1;
        check("reset_oe", pad_oe, 8'h00);
        check("reset_out", pad_out, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        check("reset_rdata", rdata, 8'h00);

        // Reset values and output path
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].adr, vecs[i].data);
            end else begin
                bus_read(vecs[i].adr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_oe", i), pad_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_out", i), pad_out, vecs[i].exp_out);
        end

        // Simultaneous write and read returns the pre-write value
        adr   = 3'd1;
        wdata = 8'h3C;
        we    = 1'b1;
        re    = 1'b1;
        tick();
        we = 1'b0;
        re = 1'b0;
        check("rw_same_rdata", rdata, 8'hAA);
        check("rw_same_out", pad_out, 8'h3C);
        tick_n(2);
        check("rdata_hold", rdata, 8'hAA);

        // Rising-edge interrupt with latency tracking
        bus_write(3'd3, 8'hFF);
        bus_write(3'd4, 8'h01);
        bus_write(3'd5, 8'h01);
        check("rise_irq_pre", {7'd0, irq}, 8'h00);
        pad_in[0] = 1'b1;
        adr = 3'd2;
        re  = 1'b1;
        tick();
        check("rise_irq_e1", {7'd0, irq}, 8'h00);
        tick();
        check("rise_irq_e2", {7'd0, irq}, 8'h00);
        check("rise_in_e2", rdata, 8'h00);
        tick();
        re = 1'b0;
        check("rise_irq_e3", {7'd0, irq}, 8'h01);
        check("rise_in_e3", rdata, 8'h01);
        bus_read(3'd3, rd);
        check("rise_iflg", rd, 8'h01);

        // Falling edge with IEN off, then enable and W1C
        bus_write(3'd4, 8'h00);
        bus_write(3'd3, 8'h01);
        check("fall_irq_clr", {7'd0, irq}, 8'h00);
        pad_in[3] = 1'b1;
        tick_n(4);
        bus_write(3'd5, 8'h00);
        bus_read(3'd3, rd);
        check("iedge_wr_no_ev", rd, 8'h00);
        pad_in[3] = 1'b0;
        tick_n(3);
        check("fall_irq_masked", {7'd0, irq}, 8'h00);
        bus_read(3'd3, rd);
        check("fall_iflg", rd, 8'h08);
        bus_write(3'd4, 8'h08);
        check("fall_irq_en", {7'd0, irq}, 8'h01);
        bus_write(3'd3, 8'h08);
        check("fall_irq_w1c", {7'd0, irq}, 8'h00);
        bus_read(3'd3, rd);
        check("fall_iflg_w1c", rd, 8'h00);

        // W1C landing on the same edge as a new rising event
        bus_write(3'd5, 8'h01);
        bus_write(3'd4, 8'h01);
        pad_in[0] = 1'b0;
        tick_n(4);
        bus_read(3'd3, rd);
        check("coll_pre_iflg", rd, 8'h00);
        pad_in[0] = 1'b1;
        tick_n(2);
        bus_write(3'd3, 8'h01);
        check("coll_irq", {7'd0, irq}, 8'h01);
        bus_read(3'd3, rd);
        check("coll_iflg", rd, 8'h01);
        tick_n(2);
        check("coll_irq_hold", {7'd0, irq}, 8'h01);

        // Mid-operation reset with a pad transition in flight
        pad_in = 8'h00;
        tick_n(4);
        bus_write(3'd5, 8'hFF);
        pad_in = 8'hFF;
        tick_n(3);
        bus_write(3'd0, 8'hFF);
        bus_read(3'd3, rd);
        check("prerst_iflg", rd, 8'hFF);
        check("prerst_oe", pad_oe, 8'hFF);
        pad_in = 8'h00;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_rdata", rdata, 8'h00);
        check("midrst_oe", pad_oe, 8'h00);
        check("midrst_out", pad_out, 8'h00);
        check("midrst_irq", {7'd0, irq}, 8'h00);
        tick_n(5);
        check("midrst_irq_late", {7'd0, irq}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            bus_read(vecs[i].adr, rd);
            check($sformatf("midrst_reg%0d", i), rd, vecs[i].exp_rd);
        end

        // Narrow instance: bits above WIDTH-1 read 0
        bus_write(3'd0, 8'hFF);
        check("w4_oe", {4'd0, pad_oe4}, 8'h0F);
        bus_read(3'd0, rd);
        check("w4_dir", rdata4, 8'h0F);
        bus_read(3'd5, rd);
        check("w4_iedge", rdata4, 8'h0F);
        bus_read(3'd7, rd);
        check("w4_id", rdata4, TbId4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
